// File: rtl/control_sequencer.sv
// control_sequencer: NSC-8 microcode sequencer; walks T-states and decodes datapath control words.
// Optional CTRL_EARLY_END_EN: each instruction ends after its last non-empty step instead of T4.
module control_sequencer #(
  parameter int N     = 8,
  parameter int STEPS = 5
) (
  input  logic           clk,
  input  logic           clear_n,
  input  logic [N/2-1:0] opcode,
  input  logic           carry_flag,
  input  logic           zero_flag,
  output logic [2:0]     step_out,
  output logic           pc_out,
  output logic           pc_inc,
  output logic           jump,
  output logic           mar_load,
  output logic           ram_out,
  output logic           ram_load,
  output logic           ir_load,
  output logic           ir_out,
  output logic           a_load,
  output logic           a_out,
  output logic           b_load,
  output logic           alu_out,
  output logic           alu_sub,
  output logic           flags_load,
  output logic           out_load,
  output logic           halt
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_e;

  localparam logic [N/2-1:0] OP_LDA = (N/2)'(4'h1);
  localparam logic [N/2-1:0] OP_ADD = (N/2)'(4'h2);
  localparam logic [N/2-1:0] OP_SUB = (N/2)'(4'h3);
  localparam logic [N/2-1:0] OP_STA = (N/2)'(4'h4);
  localparam logic [N/2-1:0] OP_LDI = (N/2)'(4'h5);
  localparam logic [N/2-1:0] OP_JMP = (N/2)'(4'h6);
  localparam logic [N/2-1:0] OP_JC  = (N/2)'(4'h7);
  localparam logic [N/2-1:0] OP_JZ  = (N/2)'(4'h8);
  localparam logic [N/2-1:0] OP_OUT = (N/2)'(4'hE);
  localparam logic [N/2-1:0] OP_HLT = (N/2)'(4'hF);

  localparam step_e LAST_STEP = step_e'(3'(STEPS - 1));

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  step_e lastStep;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    lastStep = LAST_STEP;
`ifdef CTRL_EARLY_END_EN
    case (opcode)
      OP_ADD, OP_SUB:                        lastStep = T4;
      OP_LDA, OP_STA:                        lastStep = T3;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:  lastStep = T2;
      OP_HLT:                                lastStep = LAST_STEP;
      default:                               lastStep = T1;
    endcase
`endif
    // HLT parks the sequencer on T2; only clear_n releases it.
    if (!halted_q) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == lastStep) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  assign step_out = step_q;

  always_comb begin
    pc_out     = 1'b0;
    pc_inc     = 1'b0;
    jump       = 1'b0;
    mar_load   = 1'b0;
    ram_out    = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_out     = 1'b0;
    a_load     = 1'b0;
    a_out      = 1'b0;
    b_load     = 1'b0;
    alu_out    = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halt       = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (step_q)
        T0: begin pc_out = 1'b1; mar_load = 1'b1; end
        T1: begin ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1; end
        default: begin
          // Each word keeps a single bus driver (pc/ram/ir/a/alu).
          case (opcode)
            OP_LDA: case (step_q)
              T2: begin ir_out = 1'b1; mar_load = 1'b1; end
              T3: begin ram_out = 1'b1; a_load = 1'b1; end
              default: ;
            endcase
            OP_ADD, OP_SUB: case (step_q)
              T2: begin ir_out = 1'b1; mar_load = 1'b1; end
              T3: begin ram_out = 1'b1; b_load = 1'b1; end
              T4: begin
                alu_out    = 1'b1;
                a_load     = 1'b1;
                flags_load = 1'b1;
                alu_sub    = (opcode == OP_SUB);
              end
              default: ;
            endcase
            OP_STA: case (step_q)
              T2: begin ir_out = 1'b1; mar_load = 1'b1; end
              T3: begin a_out = 1'b1; ram_load = 1'b1; end
              default: ;
            endcase
            OP_LDI: if (step_q == T2) begin ir_out = 1'b1; a_load = 1'b1; end
            OP_JMP: if (step_q == T2) begin ir_out = 1'b1; jump = 1'b1; end
            OP_JC:  if (step_q == T2 && carry_flag) begin ir_out = 1'b1; jump = 1'b1; end
            OP_JZ:  if (step_q == T2 && zero_flag) begin ir_out = 1'b1; jump = 1'b1; end
            OP_OUT: if (step_q == T2) begin a_out = 1'b1; out_load = 1'b1; end
            OP_HLT: if (step_q == T2) halt = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of fetch/execute words, halt, async clear and instruction length.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic [2:0] step_out;
  logic pc_out, pc_inc, jump, mar_load, ram_out, ram_load, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt;

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [15:0] PC_OUT     = 16'h8000;
  localparam logic [15:0] PC_INC     = 16'h4000;
  localparam logic [15:0] JUMP       = 16'h2000;
  localparam logic [15:0] MAR_LOAD   = 16'h1000;
  localparam logic [15:0] RAM_OUT    = 16'h0800;
  localparam logic [15:0] RAM_LOAD   = 16'h0400;
  localparam logic [15:0] IR_LOAD    = 16'h0200;
  localparam logic [15:0] IR_OUT     = 16'h0100;
  localparam logic [15:0] A_LOAD     = 16'h0080;
  localparam logic [15:0] A_OUT      = 16'h0040;
  localparam logic [15:0] B_LOAD     = 16'h0020;
  localparam logic [15:0] ALU_OUT    = 16'h0010;
  localparam logic [15:0] ALU_SUB    = 16'h0008;
  localparam logic [15:0] FLAGS_LOAD = 16'h0004;
  localparam logic [15:0] OUT_LOAD   = 16'h0002;
  localparam logic [15:0] HALT       = 16'h0001;

  localparam logic [15:0] FETCH0 = PC_OUT | MAR_LOAD;
  localparam logic [15:0] FETCH1 = RAM_OUT | IR_LOAD | PC_INC;

  localparam logic [15:0] LDA_WORDS [5] = '{FETCH0, FETCH1, IR_OUT | MAR_LOAD, RAM_OUT | A_LOAD, 16'h0000};
  localparam logic [15:0] SUB_WORDS [5] = '{FETCH0, FETCH1, IR_OUT | MAR_LOAD, RAM_OUT | B_LOAD,
                                            ALU_OUT | A_LOAD | FLAGS_LOAD | ALU_SUB};

  logic [15:0] ctrlWord;
  assign ctrlWord = {pc_out, pc_inc, jump, mar_load, ram_out, ram_load, ir_load, ir_out,
                     a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halt};

  always #5 clk = ~clk;

  control_sequencer #(.N(8), .STEPS(5)) dut (
    .clk(clk), .clear_n(clear_n), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .step_out(step_out), .pc_out(pc_out), .pc_inc(pc_inc), .jump(jump), .mar_load(mar_load),
    .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
    .a_out(a_out), .b_load(b_load), .alu_out(alu_out), .alu_sub(alu_sub), .flags_load(flags_load),
    .out_load(out_load), .halt(halt)
  );

  // Hand-derived instruction lengths in clocks for each build.
  function automatic int instrLen(input logic [3:0] op);
`ifdef CTRL_EARLY_END_EN
    case (op)
      4'h2, 4'h3:                   return 5;
      4'h1, 4'h4:                   return 4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE: return 3;
      default:                      return 2;
    endcase
`else
    return 5;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic checkStep(input string tag, input int expected);
    checkOutput(tag, {13'd0, step_out}, 16'(expected));
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z);
    opcode     = op;
    carry_flag = c;
    zero_flag  = z;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_n = 1'b0;
    applyStimulus(4'h1, 1'b0, 1'b0);
    #12;
    checkStep("reset_step", 0);
    checkOutput("reset_word", ctrlWord, FETCH0);
    clear_n = 1'b1;

    // LDA walk-through
    for (int i = 0; i < instrLen(4'h1); i++) begin
      checkStep($sformatf("lda_step%0d", i), i);
      checkOutput($sformatf("lda_word%0d", i), ctrlWord, LDA_WORDS[i]);
      stepClock();
    end
    checkStep("lda_wrap", 0);

    // SUB: alu_sub only in T4
    applyStimulus(4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("sub_word%0d", i), ctrlWord, SUB_WORDS[i]);
      stepClock();
    end
    checkStep("sub_wrap", 0);

    // JC taken, then carry dropped within T2
    applyStimulus(4'h7, 1'b1, 1'b0);
    repeat (2) stepClock();
    checkOutput("jc_taken", ctrlWord, IR_OUT | JUMP);
    applyStimulus(4'h7, 1'b0, 1'b0);
    #1;
    checkOutput("jc_flag_drop", ctrlWord, 16'h0000);
    repeat (instrLen(4'h7) - 2) stepClock();
    checkStep("jc_wrap", 0);

    applyStimulus(4'h7, 1'b0, 1'b1);
    repeat (2) stepClock();
    checkOutput("jc_not_taken", ctrlWord, 16'h0000);
    repeat (instrLen(4'h7) - 2) stepClock();

    applyStimulus(4'h8, 1'b0, 1'b1);
    repeat (2) stepClock();
    checkOutput("jz_taken", ctrlWord, IR_OUT | JUMP);
    applyStimulus(4'h8, 1'b1, 1'b0);
    #1;
    checkOutput("jz_not_taken", ctrlWord, 16'h0000);
    repeat (instrLen(4'h8) - 2) stepClock();
    checkStep("jz_wrap", 0);

    // ADD interrupted by clear_n in the middle of T3
    applyStimulus(4'h2, 1'b0, 1'b0);
    repeat (3) stepClock();
    checkOutput("add_t3", ctrlWord, RAM_OUT | B_LOAD);
    #2 clear_n = 1'b0;
    #1;
    checkStep("midreset_step", 0);
    checkOutput("midreset_word", ctrlWord, FETCH0);
    #1 clear_n = 1'b1;
    stepClock();
    checkStep("midreset_resume_step", 1);
    checkOutput("midreset_resume_word", ctrlWord, FETCH1);
    repeat (instrLen(4'h2) - 1) stepClock();
    checkStep("midreset_wrap", 0);

    // HLT freezes on T2 until clear_n
    applyStimulus(4'hF, 1'b0, 1'b0);
    repeat (2) stepClock();
    checkStep("hlt_t2_step", 2);
    checkOutput("hlt_t2_word", ctrlWord, HALT);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) applyStimulus(4'h0, 1'b1, 1'b1);
      stepClock();
      checkStep($sformatf("halted_step%0d", i), 2);
      checkOutput($sformatf("halted_word%0d", i), ctrlWord, HALT);
    end
    clear_n = 1'b0;
    #1;
    checkStep("unhalt_step", 0);
    checkOutput("unhalt_word", ctrlWord, FETCH0);
    clear_n = 1'b1;
    stepClock();
    checkStep("unhalt_resume", 1);
    repeat (instrLen(4'h0) - 1) stepClock();
    checkStep("unhalt_wrap", 0);

    // At most one bus driver per step, flags set to enable both conditional jumps
    for (int op = 0; op < 15; op++) begin
      applyStimulus(4'(op), 1'b1, 1'b1);
      for (int s = 0; s < instrLen(4'(op)); s++) begin
        checkOutput($sformatf("bus_op%0d_t%0d", op, s),
                    {15'd0, ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1)}, 16'h0000);
        stepClock();
      end
      checkStep($sformatf("bus_op%0d_wrap", op), 0);
    end

    // Program LDI, OUT, ADD: check each instruction's length
    begin
      logic [3:0] prog [3] = '{4'h5, 4'hE, 4'h2};
      for (int k = 0; k < 3; k++) begin
        applyStimulus(prog[k], 1'b0, 1'b0);
        repeat (instrLen(prog[k]) - 1) stepClock();
        checkStep($sformatf("prog%0d_last", k), instrLen(prog[k]) - 1);
        stepClock();
        checkStep($sformatf("prog%0d_wrap", k), 0);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the NSC-8 core.
- Consumes the opcode nibble that the instruction register drives toward the controller, plus the ALU carry and zero flags.
- Steps through T-states and drives every datapath control line: PC, MAR, RAM, IR bus buffer, A/B registers, ALU, flags and output register.
- Sits directly downstream of the instruction register's controller output.

Parameters:
- N, 8, datapath width. The opcode is N/2 bits. Only N=8 is supported.
- STEPS, 5, number of T-states per instruction, T0..T4. The step counter is clog2(STEPS) = 3 bits.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- clear_n  input  1  asynchronous, active-low reset
- opcode  input  N/2  opcode nibble from the instruction register
- carry_flag  input  1  registered ALU carry flag
- zero_flag  input  1  registered ALU zero flag
- step_out  output  3  current T-state, for debug
- pc_out, pc_inc, jump  output  1 each  program counter: drive bus / increment / load from bus
- mar_load  output  1  memory address register load
- ram_out, ram_load  output  1 each  RAM drive bus / write
- ir_load, ir_out  output  1 each  instruction register load / enable its bus buffer
- a_load, a_out, b_load  output  1 each  A register load / drive bus; B register load
- alu_out, alu_sub, flags_load  output  1 each  ALU drive bus / subtract select / flag register load
- out_load  output  1  output register load
- halt  output  1  clock-stop request

Behaviour:
- State consists of the step register (0..4) and the halted bit.
- Reset (clear_n=0, asynchronous, any time, including mid-instruction): step=0, halted=0.
  - Immediately after reset the outputs show the T0 word: pc_out=1, mar_load=1, all others 0.
- Control outputs are purely combinational from step, opcode, halted and the flags. Each word is valid for the whole step.
- Step advances on each rising clk edge. It wraps from the instruction's last step to 0.
- Fetch, for every opcode:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
  - The opcode input is valid from T2 onward.
- Execute words (unlisted steps are all zero):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load.
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load.
  - 0x3 SUB: same as ADD, with alu_sub=1 in T4 only.
  - 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_load.
  - 0x5 LDI: T2 ir_out+a_load.
  - 0x6 JMP: T2 ir_out+jump.
  - 0x7 JC: T2 ir_out+jump only if carry_flag=1, otherwise none.
  - 0x8 JZ: T2 ir_out+jump only if zero_flag=1, otherwise none.
  - 0xE OUT: T2 a_out+out_load.
  - 0xF HLT: T2 halt.
  - 0x9-0xD: undefined, treated as NOP.
- Flags are sampled combinationally during T2. A flag change in T2 is reflected in the same cycle.
- HLT: at the rising edge ending T2, halted is set and step holds at 2.
  - While halted: halt=1, all other outputs 0, step frozen.
  - Only clear_n exits the halted state.
- Invariant: at most one bus driver is asserted per step (pc_out, ram_out, ir_out, a_out, alu_out).

Optional Feature:
- Macro: CTRL_EARLY_END_EN.
- Defined: the step returns to 0 after the instruction's last non-empty step.
  - ADD/SUB: after T4.
  - LDA/STA: after T3.
  - LDI/JMP/JC/JZ/OUT: after T2, including not-taken JC/JZ.
  - NOP/undefined: after T1.
  - HLT is unchanged.
- Undefined: every instruction runs the full T0..T4 and wraps after T4.

Test Plan:
- Drop clear_n mid-T3 of ADD, then release -> step_out=0 immediately; pc_out=1 and mar_load=1 with all others 0; fetch resumes on the next edge.
- opcode=0x1 (LDA), run 5 clocks from T0 -> observed words match in order: {pc_out,mar_load}, {ram_out,ir_load,pc_inc}, {ir_out,mar_load}, {ram_out,a_load}, {}; step_out then wraps to 0.
- opcode=0x3 (SUB) at T4 -> alu_out=1, a_load=1, flags_load=1, alu_sub=1; alu_sub=0 in T0-T3.
- opcode=0x7 (JC): carry_flag=1 in T2 -> jump=1 and ir_out=1; repeat with carry_flag=0 -> jump=0 and ir_out=0.
- opcode=0xF (HLT), then 10 further clocks -> halt=1, step_out=2, all other outputs 0 throughout; clear_n pulse restores step_out=0 and halt=0.
- With CTRL_EARLY_END_EN, program sequence LDI, OUT, ADD -> 3+3+5 = 11 clocks per pass, and step_out returns to 0 after each instruction. Without the macro -> 15 clocks.
- Over all opcodes and steps, check that at most one bus driver is asserted per step.
